// File: rtl/keypad_hit_filter.sv
// keypad_hit_filter
// Conditions the raw 8-key keypad for the game core. The block first
// synchronises the keypad into the clock domain and debounces the whole
// vector. It rejects multi-key chords and turns each clean single-key press
// into a one-hot hit. That hit is held until the game core acknowledges it
// on its slow tick.
module keypad_hit_filter #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 18
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic [7:0] keypad,
    input  logic       enable,
    input  logic       hit_ack,
    output logic       hit_valid,
    output logic [7:0] hit_key,
    output logic [2:0] hit_idx,
    output logic       overrun,
    output logic       multi_err
);

    // Terminal count: the vector must match the candidate for this many
    // consecutive cycles after being captured before it is accepted.
    localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_HELD  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Number of keys set in a vector.
    function automatic logic [3:0] f_popcount(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    // Binary index of a one-hot vector (0 for an all-zero vector).
    function automatic logic [2:0] f_onehot_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]       r_s1;
    logic [7:0]       r_s2;
    logic [7:0]       r_cand;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_stable;
    logic [7:0]       r_stable_d;

    state_t           r_state;
    logic             r_hit_valid;
    logic [7:0]       r_hit_key;
    logic [2:0]       r_hit_idx;
    logic             r_overrun;
    logic             r_multi_err;

    // Event-detect results
    logic             w_changed;
    logic [7:0]       w_rise;
    logic             w_multi;
    logic             w_press;

    // Hit-register next values
    state_t           w_state_nxt;
    logic [7:0]       w_key_nxt;
    logic [2:0]       w_idx_nxt;
    logic             w_ovr_nxt;
    logic             w_multi_nxt;

    // ------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------

    // Two-flop synchroniser for the asynchronous keypad vector.
    always_ff @(posedge clk) begin
        if (RESET) begin
            r_s1 <= 8'h00;
            r_s2 <= 8'h00;
        end else begin
            r_s1 <= keypad;
            r_s2 <= r_s1;
        end
    end

    // ------------------------------------------------------------------
    // Debounce
    // ------------------------------------------------------------------

    // Any change restarts the count; once the count saturates the
    // candidate becomes the accepted vector.
    always_ff @(posedge clk) begin
        if (RESET) begin
            r_cand   <= 8'h00;
            r_cnt    <= '0;
            r_stable <= 8'h00;
        end else if (r_s2 != r_cand) begin
            r_cand <= r_s2;
            r_cnt  <= '0;
        end else if (r_cnt == LP_CNT_MAX) begin
            r_stable <= r_cand;
        end else begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // One-cycle delayed copy of the accepted vector for edge detection.
    always_ff @(posedge clk) begin
        if (RESET) begin
            r_stable_d <= 8'h00;
        end else begin
            r_stable_d <= r_stable;
        end
    end

    // ------------------------------------------------------------------
    // Event detect
    // ------------------------------------------------------------------

    // Chords raise an error. A single new key raises a press. Releases and
    // held keys produce nothing because only a rising bit can press.
    always_comb begin
        w_changed = (r_stable != r_stable_d);
        w_rise    = r_stable & ~r_stable_d;
        w_multi   = 1'b0;
        w_press   = 1'b0;
        if (w_changed) begin
            if (f_popcount(r_stable) > 4'd1) begin
                w_multi = 1'b1;
            end else if (f_popcount(w_rise) == 4'd1) begin
                w_press = 1'b1;
            end else begin
                w_press = 1'b0;
            end
        end else begin
            w_multi = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Hit register FSM
    // ------------------------------------------------------------------

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (RESET) begin
            r_state     <= ST_EMPTY;
            r_hit_valid <= 1'b0;
            r_hit_key   <= 8'h00;
            r_hit_idx   <= 3'd0;
            r_overrun   <= 1'b0;
            r_multi_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hit_valid <= (w_state_nxt == ST_HELD);
            r_hit_key   <= w_key_nxt;
            r_hit_idx   <= w_idx_nxt;
            r_overrun   <= w_ovr_nxt;
            r_multi_err <= w_multi_nxt;
        end
    end

    // Next-state logic. The first hit wins over later presses. An ack in
    // the same cycle as a press lets the new press replace the held hit.
    always_comb begin
        w_state_nxt = r_state;
        w_key_nxt   = r_hit_key;
        w_idx_nxt   = r_hit_idx;
        w_ovr_nxt   = 1'b0;
        w_multi_nxt = w_multi;
        case (r_state)
            ST_EMPTY: begin
                if (w_press && enable) begin
                    w_state_nxt = ST_HELD;
                    w_key_nxt   = w_rise;
                    w_idx_nxt   = f_onehot_idx(w_rise);
                end else begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_HELD: begin
                if (hit_ack) begin
                    if (w_press && enable) begin
                        w_state_nxt = ST_HELD;
                        w_key_nxt   = w_rise;
                        w_idx_nxt   = f_onehot_idx(w_rise);
                    end else begin
                        w_state_nxt = ST_EMPTY;
                        w_key_nxt   = 8'h00;
                        w_idx_nxt   = 3'd0;
                    end
                end else if (w_press) begin
                    w_ovr_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_HELD;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
                w_key_nxt   = 8'h00;
                w_idx_nxt   = 3'd0;
            end
        endcase
    end

    assign hit_valid = r_hit_valid;
    assign hit_key   = r_hit_key;
    assign hit_idx   = r_hit_idx;
    assign overrun   = r_overrun;
    assign multi_err = r_multi_err;

endmodule

// File: tb/tb_keypad_hit_filter.sv
// Self-checking bench for keypad_hit_filter. The reference model decides
// the debounced vector from a window of past keypad samples. It accepts a
// value once D+1 consecutive samples agree. The hit register is modelled as
// a held flag plus a key.
module tb_keypad_hit_filter;

    localparam int D = 4;

    logic       clk;
    logic       RESET;
    logic [7:0] keypad;
    logic       enable;
    logic       hit_ack;
    logic       hit_valid;
    logic [7:0] hit_key;
    logic [2:0] hit_idx;
    logic       overrun;
    logic       multi_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state
    logic [7:0] m_q[$];
    logic [7:0] m_stable, m_stable_d, m_key;
    logic       m_held, e_ov, e_me;

    // Segment event counters (observed DUT behaviour)
    int  cnt_rise, cnt_ov, cnt_me;
    logic prev_valid;

    keypad_hit_filter #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
        .clk(clk), .RESET(RESET), .keypad(keypad), .enable(enable),
        .hit_ack(hit_ack), .hit_valid(hit_valid), .hit_key(hit_key),
        .hit_idx(hit_idx), .overrun(overrun), .multi_err(multi_err)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2:0] idx_of(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) if (v == (8'h01 << i)) r = 3'(i);
        return r;
    endfunction

    // Reference model: one clock edge with the given sampled inputs.
    task automatic model_edge(input logic [7:0] kp, input logic en, input logic ack, input logic rst);
        logic [7:0] rise, nst, ref_v;
        bit press, multi, eq;
        if (rst) begin
            m_q.delete();
            for (int i = 0; i < D + 2; i++) m_q.push_back(8'h00);
            m_stable = 8'h00; m_stable_d = 8'h00;
            m_held = 1'b0; m_key = 8'h00; e_ov = 1'b0; e_me = 1'b0;
        end else begin
            press = 0; multi = 0;
            rise = m_stable & ~m_stable_d;
            if (m_stable != m_stable_d) begin
                if ($countones(m_stable) > 1) multi = 1;
                else if ($countones(rise) == 1) press = 1;
            end
            e_me = multi;
            e_ov = 1'b0;
            if (m_held) begin
                if (ack) begin
                    if (press && en) m_key = rise;
                    else begin m_held = 1'b0; m_key = 8'h00; end
                end else if (press) begin
                    e_ov = 1'b1;
                end
            end else if (press && en) begin
                m_held = 1'b1; m_key = rise;
            end
            // Accept a value seen in D+1 consecutive samples ending two edges ago
            ref_v = m_q[m_q.size() - 2];
            eq = 1;
            for (int i = 0; i <= D; i++) if (m_q[m_q.size() - 2 - i] != ref_v) eq = 0;
            nst = eq ? ref_v : m_stable;
            m_stable_d = m_stable;
            m_stable = nst;
            m_q.push_back(kp);
            if (m_q.size() > D + 2) void'(m_q.pop_front());
        end
    endtask

    task automatic step(input logic [7:0] kp, input logic en, input logic ack, input logic rst);
        keypad = kp; enable = en; hit_ack = ack; RESET = rst;
        @(posedge clk);
        model_edge(kp, en, ack, rst);
        #1;
        check_eq("hit_valid", 32'(hit_valid), 32'(m_held));
        check_eq("hit_key",   32'(hit_key),   32'(m_key));
        check_eq("hit_idx",   32'(hit_idx),   32'(idx_of(m_key)));
        check_eq("overrun",   32'(overrun),   32'(e_ov));
        check_eq("multi_err", 32'(multi_err), 32'(e_me));
        if (hit_valid === 1'b1 && prev_valid !== 1'b1) cnt_rise++;
        if (overrun === 1'b1) cnt_ov++;
        if (multi_err === 1'b1) cnt_me++;
        prev_valid = hit_valid;
    endtask

    task automatic hold(input logic [7:0] kp, input logic en, input int n);
        for (int i = 0; i < n; i++) step(kp, en, 1'b0, 1'b0);
    endtask

    task automatic clear_counts();
        cnt_rise = 0; cnt_ov = 0; cnt_me = 0;
    endtask

    initial begin
        logic [7:0] kp;
        int len, sel;
        logic en, ack, rst;
        prev_valid = 1'b0;
        clear_counts();

        // 1. Clean press
        step(8'h00, 1'b1, 1'b0, 1'b1);
        step(8'h00, 1'b1, 1'b0, 1'b1);
        check_eq("reset_valid", 32'(hit_valid), 32'd0);
        check_eq("reset_key", 32'(hit_key), 32'd0);
        for (int i = 1; i <= 60; i++) begin
            step(8'h08, 1'b1, 1'b0, 1'b0);
            if (i == 7) check_eq("t1_not_yet", 32'(hit_valid), 32'd0);
            if (i == 8) begin
                check_eq("t1_valid", 32'(hit_valid), 32'd1);
                check_eq("t1_key", 32'(hit_key), 32'h08);
                check_eq("t1_idx", 32'(hit_idx), 32'd3);
            end
        end
        check_eq("t1_still_held", 32'(hit_valid), 32'd1);
        step(8'h08, 1'b1, 1'b1, 1'b0);
        check_eq("t1_ack_valid", 32'(hit_valid), 32'd0);
        check_eq("t1_ack_key", 32'(hit_key), 32'd0);
        hold(8'h00, 1'b1, 10);

        // 2. Bounce
        clear_counts();
        for (int i = 0; i < 10; i++) begin
            kp = (((i >> 1) & 1) == 0) ? 8'h01 : 8'h00;
            step(kp, 1'b1, 1'b0, 1'b0);
        end
        for (int k = 1; k <= 20; k++) begin
            step(8'h01, 1'b1, 1'b0, 1'b0);
            if (k == 5) check_eq("t2_not_yet", 32'(hit_valid), 32'd0);
            if (k == 6) check_eq("t2_valid", 32'(hit_valid), 32'd1);
        end
        check_eq("t2_hits", 32'(cnt_rise), 32'd1);
        check_eq("t2_idx", 32'(hit_idx), 32'd0);
        check_eq("t2_overrun", 32'(cnt_ov), 32'd0);
        step(8'h01, 1'b1, 1'b1, 1'b0);
        hold(8'h00, 1'b1, 10);

        // 3. Chord, then long hold
        clear_counts();
        hold(8'h81, 1'b1, 20);
        check_eq("t3_multi", 32'(cnt_me), 32'd1);
        check_eq("t3_chord_hits", 32'(cnt_rise), 32'd0);
        hold(8'h00, 1'b1, 10);
        clear_counts();
        hold(8'h04, 1'b1, 30);
        step(8'h04, 1'b1, 1'b1, 1'b0);
        hold(8'h04, 1'b1, 70);
        check_eq("t3_hold_hits", 32'(cnt_rise), 32'd1);
        check_eq("t3_no_repeat", 32'(hit_valid), 32'd0);
        hold(8'h00, 1'b1, 10);

        // 4. Overrun, then ack-and-reload
        hold(8'h02, 1'b1, 15);
        hold(8'h00, 1'b1, 10);
        clear_counts();
        hold(8'h10, 1'b1, 15);
        check_eq("t4_overrun", 32'(cnt_ov), 32'd1);
        check_eq("t4_first_wins", 32'(hit_key), 32'h02);
        hold(8'h00, 1'b1, 10);
        step(8'h00, 1'b1, 1'b1, 1'b0);
        hold(8'h02, 1'b1, 15);
        hold(8'h00, 1'b1, 10);
        clear_counts();
        for (int k = 1; k <= 8; k++) step(8'h20, 1'b1, 1'(k == 8), 1'b0);
        check_eq("t4_reload_valid", 32'(hit_valid), 32'd1);
        check_eq("t4_reload_key", 32'(hit_key), 32'h20);
        check_eq("t4_reload_ov", 32'(cnt_ov), 32'd0);
        step(8'h20, 1'b1, 1'b1, 1'b0);
        hold(8'h00, 1'b1, 10);

        // 5. Enable gating
        clear_counts();
        hold(8'h40, 1'b0, 15);
        hold(8'h00, 1'b0, 10);
        check_eq("t5_no_hit", 32'(cnt_rise), 32'd0);
        check_eq("t5_no_ov", 32'(cnt_ov), 32'd0);
        check_eq("t5_no_me", 32'(cnt_me), 32'd0);
        hold(8'h08, 1'b1, 12);
        hold(8'h00, 1'b0, 20);
        check_eq("t5_held", 32'(hit_valid), 32'd1);
        step(8'h00, 1'b0, 1'b1, 1'b0);
        check_eq("t5_ack", 32'(hit_valid), 32'd0);

        // 6. Reset mid-operation
        hold(8'h02, 1'b1, 12);
        hold(8'h04, 1'b1, 3);
        step(8'h04, 1'b1, 1'b0, 1'b1);
        check_eq("t6_rst_valid", 32'(hit_valid), 32'd0);
        check_eq("t6_rst_key", 32'(hit_key), 32'd0);
        for (int k = 1; k <= 10; k++) begin
            step(8'h04, 1'b1, 1'b0, 1'b0);
            if (k == 7) check_eq("t6_not_yet", 32'(hit_valid), 32'd0);
            if (k == 8) begin
                check_eq("t6_valid", 32'(hit_valid), 32'd1);
                check_eq("t6_key", 32'(hit_key), 32'h04);
            end
        end

        // Randomised traffic against the model
        for (int n = 0; n < 500; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4)       kp = 8'h00;
            else if (sel < 8)  kp = 8'h01 << $urandom_range(0, 7);
            else if (sel == 8) kp = 8'($urandom);
            else               kp = (8'h01 << $urandom_range(0, 7)) | (8'h01 << $urandom_range(0, 7));
            len = $urandom_range(1, 12);
            for (int c = 0; c < len; c++) begin
                en  = ($urandom_range(0, 9) != 0);
                ack = ($urandom_range(0, 5) == 0);
                rst = ($urandom_range(0, 299) == 0);
                step(kp, en, ack, rst);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
